// File: rtl/sd_spi_pkg.sv
// Shared constants and types for the SPI-mode SD card responder.
// Holds the command indices, tokens, R1 bit masks, the OCR value and the FSM enums.
package sd_spi_pkg;

  localparam logic [5:0] CMD_GO_IDLE       = 6'd0;
  localparam logic [5:0] CMD_SEND_IF_COND  = 6'd8;
  localparam logic [5:0] CMD_SET_BLOCKLEN  = 6'd16;
  localparam logic [5:0] CMD_READ_SINGLE   = 6'd17;
  localparam logic [5:0] CMD_WRITE_SINGLE  = 6'd24;
  localparam logic [5:0] CMD_APP           = 6'd55;
  localparam logic [5:0] ACMD_SEND_OP_COND = 6'd41;
  localparam logic [5:0] CMD_READ_OCR      = 6'd58;

  localparam logic [7:0] TOKEN_START  = 8'hFE;
  localparam logic [7:0] DRESP_OK     = 8'h05;

  localparam logic [7:0] R1_IDLE      = 8'h01;
  localparam logic [7:0] R1_ILLEGAL   = 8'h04;
  localparam logic [7:0] R1_ADDR_ERR  = 8'h20;
  localparam logic [7:0] R1_PARAM_ERR = 8'h40;

  localparam logic [31:0] OCR_VALUE   = 32'hC0FF8000;

  typedef enum logic [3:0] {
    ST_HUNT, ST_CMD, ST_NCR, ST_RESP,
    ST_RD_NAC, ST_RD_DATA, ST_RD_CRC,
    ST_WR_TOKEN, ST_WR_DATA, ST_WR_CRC, ST_WR_BUSY
  } state_e;

  typedef enum logic [1:0] {ACT_NONE, ACT_READ, ACT_WRITE} act_e;

endpackage

// File: rtl/sd_spi_slave_phy.sv
// SPI mode-0 target PHY: synchronizes cs/sclk/mosi into clk, shifts bytes MSB first.
// Ports: cs/sclk/mosi raw SPI inputs; miso output; cs_active synced select;
//   rx_valid/rx_byte one-cycle pulse per received byte; tx_load/tx_byte next byte to send.
module sd_spi_slave_phy
  import sd_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       miso,
  output logic       cs_active,
  output logic       rx_valid,
  output logic [7:0] rx_byte
);

  logic [1:0] cs_sync_q, mosi_sync_q;
  logic [2:0] sclk_sync_q;
  logic       sclk_rise, sclk_fall;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, rx_byte_q, rx_byte_d, tx_src;
  logic       miso_q, miso_d, rx_valid_q, rx_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], cs};
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
    end
  end

  assign cs_active = ~cs_sync_q[1];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    miso_d     = miso_q;
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    // a load coinciding with a fall still drives the new MSB
    tx_src     = tx_load ? tx_byte : tx_sh_q;
    if (!cs_active) begin
      bit_cnt_d = '0;
      tx_sh_d   = '1;
      miso_d    = 1'b1;
    end else begin
      if (sclk_rise) begin
        rx_sh_d   = {rx_sh_q[6:0], mosi_sync_q[1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_valid_d = 1'b1;
          rx_byte_d  = {rx_sh_q[6:0], mosi_sync_q[1]};
        end
      end
      if (sclk_fall) begin
        miso_d  = tx_src[7];
        tx_sh_d = {tx_src[6:0], 1'b1};
      end else begin
        tx_sh_d = tx_src;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '1;
      miso_q     <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  assign miso     = miso_q;
  assign rx_valid = rx_valid_q;
  assign rx_byte  = rx_byte_q;

endmodule

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SDHC card emulator backed by a byte-wide block memory (512 B blocks).
// Ports: clk/rst; cs/sclk/mosi/miso/miso_oe SPI target side; mem_addr/mem_rd_en/mem_rdata/
//   mem_we/mem_wdata memory port; init_done after ACMD41 completes; busy during data phases.
// Each received byte decides the byte sent in the following byte slot.
module sd_spi_card_responder
  import sd_spi_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int NCR_BYTES  = 1,
  parameter int NAC_BYTES  = 1,
  parameter int BUSY_BYTES = 4,
  parameter int INIT_POLLS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              init_done,
  output logic              busy
);

  localparam logic [7:0] NCR_N  = 8'(NCR_BYTES);
  localparam logic [7:0] NAC_N  = 8'(NAC_BYTES);
  localparam logic [7:0] BUSY_N = 8'(BUSY_BYTES);
  localparam logic [7:0] POLL_N = 8'(INIT_POLLS);
  localparam int BLK_W = ADDR_W - 9;

  logic cs_active, rx_valid;
  logic [7:0] rx_byte;

  state_e state_q, state_d;
  act_e act_q, act_d;
  logic [7:0] cnt_q, cnt_d, poll_q, poll_d, tx_byte_q, tx_byte_d, rbuf_q, rbuf_d, wdata_q, wdata_d;
  logic [8:0] off_q, off_d;
  logic [31:0] arg_q, arg_d, resp_q, resp_d;
  logic [5:0] idx_q, idx_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [2:0] rcnt_q, rcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic app_q, app_d, init_q, init_d, tx_load_q, tx_load_d;
  logic rd_en_q, rd_en_d, we_q, we_d, rd_pend_q;
  logic [7:0] r1;
  logic idle;

  sd_spi_slave_phy u_phy (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi),
    .tx_load(tx_load_q), .tx_byte(tx_byte_q), .miso(miso),
    .cs_active(cs_active), .rx_valid(rx_valid), .rx_byte(rx_byte)
  );

  always_comb begin
    state_d = state_q; act_d = act_q; cnt_d = cnt_q; poll_d = poll_q;
    off_d = off_q; arg_d = arg_q; resp_d = resp_q; idx_d = idx_q; blk_d = blk_q;
    rcnt_d = rcnt_q; addr_d = addr_q; wdata_d = wdata_q; app_d = app_q; init_d = init_q;
    tx_byte_d = tx_byte_q; tx_load_d = 1'b0; rd_en_d = 1'b0; we_d = 1'b0;
    rbuf_d = rd_pend_q ? mem_rdata : rbuf_q;
    idle = ~init_q;
    r1 = 8'h00;
    if (!cs_active) begin
      state_d = ST_HUNT;
    end else if (rx_valid) begin
      tx_load_d = 1'b1;
      tx_byte_d = 8'hFF;
      case (state_q)
        ST_HUNT: if (rx_byte[7:6] == 2'b01) begin
          idx_d = rx_byte[5:0]; cnt_d = '0; state_d = ST_CMD;
        end
        ST_CMD: if (cnt_q == 8'd4) begin
          state_d = ST_NCR; cnt_d = 8'd1;
        end else begin
          arg_d = {arg_q[23:0], rx_byte}; cnt_d = cnt_q + 8'd1;
        end
        ST_NCR: if (cnt_q == NCR_N) begin
          resp_d = '0; rcnt_d = '0; act_d = ACT_NONE; app_d = 1'b0;
          if (app_q && idx_q == ACMD_SEND_OP_COND) begin
            if (init_q) r1 = 8'h00;
            else if (poll_q < POLL_N) begin poll_d = poll_q + 8'd1; r1 = R1_IDLE; end
            else begin init_d = 1'b1; r1 = 8'h00; end
          end else begin
            case (idx_q)
              CMD_GO_IDLE: begin init_d = 1'b0; poll_d = '0; r1 = R1_IDLE; end
              CMD_SEND_IF_COND: begin r1 = {7'd0, idle}; resp_d = arg_q; rcnt_d = 3'd4; end
              CMD_APP: begin r1 = {7'd0, idle}; app_d = 1'b1; end
              CMD_READ_OCR: begin r1 = {7'd0, idle}; resp_d = OCR_VALUE; rcnt_d = 3'd4; end
              CMD_SET_BLOCKLEN: r1 = (arg_q == 32'd512) ? {7'd0, idle} : (R1_PARAM_ERR | {7'd0, idle});
              CMD_READ_SINGLE, CMD_WRITE_SINGLE: begin
                if (!init_q) r1 = R1_ILLEGAL | {7'd0, idle};
                else if (arg_q[31:BLK_W] != '0) r1 = R1_ADDR_ERR;
                else begin
                  r1 = 8'h00; blk_d = arg_q[BLK_W-1:0];
                  act_d = (idx_q == CMD_READ_SINGLE) ? ACT_READ : ACT_WRITE;
                end
              end
              default: r1 = R1_ILLEGAL | {7'd0, idle};
            endcase
          end
          tx_byte_d = r1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        ST_RESP: if (rcnt_q != '0) begin
          tx_byte_d = resp_q[31:24]; resp_d = {resp_q[23:0], 8'h00}; rcnt_d = rcnt_q - 3'd1;
        end else begin
          case (act_q)
            ACT_READ:  begin state_d = ST_RD_NAC; cnt_d = 8'd1; end
            ACT_WRITE: state_d = ST_WR_TOKEN;
            default:   state_d = ST_HUNT;
          endcase
        end
        ST_RD_NAC: if (cnt_q == NAC_N) begin
          tx_byte_d = TOKEN_START; off_d = '0; addr_d = {blk_q, 9'd0}; rd_en_d = 1'b1;
          state_d = ST_RD_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        // rbuf holds byte off_q; fetch off_q+1 now so it is ready by the next boundary
        ST_RD_DATA: begin
          tx_byte_d = rbuf_q;
          if (off_q == 9'd511) begin
            state_d = ST_RD_CRC; cnt_d = '0;
          end else begin
            off_d = off_q + 9'd1; addr_d = {blk_q, off_q + 9'd1}; rd_en_d = 1'b1;
          end
        end
        ST_RD_CRC: if (cnt_q == 8'd1) state_d = ST_HUNT; else cnt_d = 8'd1;
        ST_WR_TOKEN: if (rx_byte == TOKEN_START) begin
          state_d = ST_WR_DATA; off_d = '0;
        end else if (rx_byte != 8'hFF) begin
          state_d = ST_HUNT;
        end
        ST_WR_DATA: begin
          we_d = 1'b1; addr_d = {blk_q, off_q}; wdata_d = rx_byte;
          if (off_q == 9'd511) begin state_d = ST_WR_CRC; cnt_d = '0; end
          else off_d = off_q + 9'd1;
        end
        ST_WR_CRC: if (cnt_q == 8'd1) begin
          tx_byte_d = DRESP_OK; state_d = ST_WR_BUSY; cnt_d = '0;
        end else begin
          cnt_d = 8'd1;
        end
        ST_WR_BUSY: if (cnt_q < BUSY_N) begin
          tx_byte_d = 8'h00; cnt_d = cnt_q + 8'd1;
        end else begin
          state_d = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HUNT; act_q <= ACT_NONE; cnt_q <= '0; poll_q <= '0; off_q <= '0;
      arg_q <= '0; resp_q <= '0; idx_q <= '0; blk_q <= '0; rcnt_q <= '0;
      addr_q <= '0; wdata_q <= '0; app_q <= 1'b0; init_q <= 1'b0;
      tx_byte_q <= '1; tx_load_q <= 1'b0; rd_en_q <= 1'b0; we_q <= 1'b0;
      rd_pend_q <= 1'b0; rbuf_q <= '0;
    end else begin
      state_q <= state_d; act_q <= act_d; cnt_q <= cnt_d; poll_q <= poll_d; off_q <= off_d;
      arg_q <= arg_d; resp_q <= resp_d; idx_q <= idx_d; blk_q <= blk_d; rcnt_q <= rcnt_d;
      addr_q <= addr_d; wdata_q <= wdata_d; app_q <= app_d; init_q <= init_d;
      tx_byte_q <= tx_byte_d; tx_load_q <= tx_load_d; rd_en_q <= rd_en_d; we_q <= we_d;
      rd_pend_q <= rd_en_q; rbuf_q <= rbuf_d;
    end
  end

  assign miso_oe   = cs_active;
  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_en_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign init_done = init_q;
  assign busy      = state_q inside {ST_RD_NAC, ST_RD_DATA, ST_RD_CRC,
                                     ST_WR_TOKEN, ST_WR_DATA, ST_WR_CRC, ST_WR_BUSY};

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Bench for sd_spi_card_responder: bit-banged SPI host, behavioural RAM, scoreboard monitor.
module tb_sd_spi_card_responder;

  localparam int ADDR_W = 20;
  localparam int HALF   = 40;

  logic clk = 1'b0;
  logic rst, cs, sclk, mosi, miso, miso_oe, mem_rd_en, mem_we, init_done, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  sd_spi_card_responder #(.ADDR_W(ADDR_W), .NCR_BYTES(1), .NAC_BYTES(1),
                          .BUSY_BYTES(4), .INIT_POLLS(2)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .init_done(init_done), .busy(busy)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // scoreboard queues: expected values are pushed by the stimulus side
  logic [15:0] exp_q[$], got_q[$];
  logic [ADDR_W+7:0] wr_exp_q[$];
  logic [31:0] sg_q[$], se_q[$];
  string sn_q[$];
  int checks = 0, errors = 0, wr_cnt = 0;
  logic [15:0] g, e;
  logic [ADDR_W+7:0] w;
  logic [31:0] sg, se;
  string sn;

  always @(negedge clk) begin
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL miso_byte test%0d: got %h required %h", e[15:8], g[7:0], e[7:0]);
      end
    end
    while (sg_q.size() > 0) begin
      sg = sg_q.pop_front(); se = se_q.pop_front(); sn = sn_q.pop_front();
      checks++;
      if (sg !== se) begin
        errors++;
        $display("FAIL %s: got %h required %h", sn, sg, se);
      end
    end
    if (mem_we) begin
      wr_cnt++;
      checks++;
      if (wr_exp_q.size() == 0) begin
        errors++;
        $display("FAIL mem_write: unexpected write addr %h data %h", mem_addr, mem_wdata);
      end else begin
        w = wr_exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== w) begin
          errors++;
          $display("FAIL mem_write: got addr %h data %h required addr %h data %h",
                   mem_addr, mem_wdata, w[ADDR_W+7:8], w[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    sn_q.push_back(name); sg_q.push_back(got); se_q.push_back(req);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #HALF sclk = 1'b1;
      rx[i] = miso;
      #HALF sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] r;
    xfer(tx, r);
  endtask

  task automatic xchk(input logic [7:0] tx, input logic [7:0] req, input logic [7:0] tag);
    logic [7:0] r;
    xfer(tx, r);
    exp_q.push_back({tag, req});
    got_q.push_back({tag, r});
  endtask

  task automatic cmd_r1(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                        input logic [7:0] r1, input logic [7:0] tag);
    send({2'b01, idx});
    send(arg[31:24]); send(arg[23:16]); send(arg[15:8]); send(arg[7:0]);
    send(crc);
    xchk(8'hFF, 8'hFF, tag);
    xchk(8'hFF, r1, tag);
  endtask

  task automatic cs_on();
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_off();
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #980us;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int wbase;
    logic busy_all;
    logic [7:0] d;
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_miso", miso, 1); chk("rst_miso_oe", miso_oe, 0);
    chk("rst_mem_ctl", {mem_rd_en, mem_we}, 0); chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_init_done", init_done, 0); chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: CMD0, miso_oe follows cs
    cs_on();
    chk("miso_oe_low_cs", miso_oe, 1);
    cmd_r1(6'd0, 32'h0, 8'h95, 8'h01, 8'd1);
    cs_off();
    chk("miso_oe_high_cs", miso_oe, 0);

    // 2: CMD8 echo, early CMD17, CMD16 arguments, unknown command
    cs_on();
    cmd_r1(6'd8, 32'h000001AA, 8'h87, 8'h01, 8'd2);
    xchk(8'hFF, 8'h00, 8'd2); xchk(8'hFF, 8'h00, 8'd2);
    xchk(8'hFF, 8'h01, 8'd2); xchk(8'hFF, 8'hAA, 8'd2);
    cs_off(); cs_on();
    cmd_r1(6'd17, 32'h0, 8'hFF, 8'h05, 8'd2);
    cs_off(); cs_on();
    cmd_r1(6'd16, 32'd512, 8'hFF, 8'h01, 8'd2);
    cmd_r1(6'd16, 32'd256, 8'hFF, 8'h41, 8'd2);
    cmd_r1(6'd2, 32'h0, 8'hFF, 8'h05, 8'd2);
    cs_off();

    // 3: ACMD41 polling, CMD58, CMD16 after init
    cs_on();
    cmd_r1(6'd55, 32'h0, 8'hFF, 8'h01, 8'd3); cmd_r1(6'd41, 32'h40000000, 8'hFF, 8'h01, 8'd3);
    cmd_r1(6'd55, 32'h0, 8'hFF, 8'h01, 8'd3); cmd_r1(6'd41, 32'h40000000, 8'hFF, 8'h01, 8'd3);
    repeat (4) @(negedge clk);
    chk("init_done_polling", init_done, 0);
    cmd_r1(6'd55, 32'h0, 8'hFF, 8'h01, 8'd3); cmd_r1(6'd41, 32'h40000000, 8'hFF, 8'h00, 8'd3);
    repeat (4) @(negedge clk);
    chk("init_done_set", init_done, 1);
    cmd_r1(6'd58, 32'h0, 8'hFF, 8'h00, 8'd3);
    xchk(8'hFF, 8'hC0, 8'd3); xchk(8'hFF, 8'hFF, 8'd3);
    xchk(8'hFF, 8'h80, 8'd3); xchk(8'hFF, 8'h00, 8'd3);
    cmd_r1(6'd16, 32'd512, 8'hFF, 8'h00, 8'd3);
    cs_off();

    // 4: CMD24 block 3
    wbase = wr_cnt;
    cs_on();
    cmd_r1(6'd24, 32'd3, 8'hFF, 8'h00, 8'd4);
    xchk(8'hFF, 8'hFF, 8'd4);
    xchk(8'hFE, 8'hFF, 8'd4);
    repeat (4) @(negedge clk);
    chk("busy_wr_data", busy, 1);
    for (int i = 0; i < 512; i++) begin
      d = 8'(i) ^ 8'h5A;
      wr_exp_q.push_back({ADDR_W'(32'h600 + i), d});
      send(d);
    end
    send(8'hFF); send(8'hFF);
    xchk(8'hFF, 8'h05, 8'd4);
    for (int i = 0; i < 4; i++) xchk(8'hFF, 8'h00, 8'd4);
    xchk(8'hFF, 8'hFF, 8'd4);
    repeat (4) @(negedge clk);
    chk("busy_wr_done", busy, 0);
    chk("wr_count_full", 32'(wr_cnt - wbase), 512);
    cs_off();

    // 5: CMD17 block 3 reads back
    cs_on();
    cmd_r1(6'd17, 32'd3, 8'hFF, 8'h00, 8'd5);
    xchk(8'hFF, 8'hFF, 8'd5);
    xchk(8'hFF, 8'hFE, 8'd5);
    busy_all = 1'b1;
    for (int i = 0; i < 512; i++) begin
      xchk(8'hFF, 8'(i) ^ 8'h5A, 8'd5);
      busy_all = busy_all & busy;
    end
    xchk(8'hFF, 8'hFF, 8'd5); xchk(8'hFF, 8'hFF, 8'd5);
    chk("busy_rd_data", busy_all, 1);
    repeat (4) @(negedge clk);
    chk("busy_rd_done", busy, 0);
    cs_off();

    // 6: aborted write, out-of-range block, bad token, CMD0
    wbase = wr_cnt;
    cs_on();
    cmd_r1(6'd24, 32'd5, 8'hFF, 8'h00, 8'd6);
    xchk(8'hFF, 8'hFF, 8'd6);
    send(8'hFE);
    for (int i = 0; i < 100; i++) begin
      d = 8'(i + 7);
      wr_exp_q.push_back({ADDR_W'(32'hA00 + i), d});
      send(d);
    end
    cs_off();
    chk("busy_cs_abort", busy, 0);
    chk("wr_count_abort", 32'(wr_cnt - wbase), 100);
    cs_on();
    cmd_r1(6'd17, 32'd2048, 8'hFF, 8'h20, 8'd6);
    cs_off();
    wbase = wr_cnt;
    cs_on();
    cmd_r1(6'd24, 32'd4, 8'hFF, 8'h00, 8'd6);
    xchk(8'hFF, 8'hFF, 8'd6);
    xchk(8'h55, 8'hFF, 8'd6);
    cmd_r1(6'd58, 32'h0, 8'hFF, 8'h00, 8'd6);
    xchk(8'hFF, 8'hC0, 8'd6); xchk(8'hFF, 8'hFF, 8'd6);
    xchk(8'hFF, 8'h80, 8'd6); xchk(8'hFF, 8'h00, 8'd6);
    chk("wr_count_bad_token", 32'(wr_cnt - wbase), 0);
    cmd_r1(6'd0, 32'h0, 8'h95, 8'h01, 8'd6);
    repeat (4) @(negedge clk);
    chk("init_done_cmd0", init_done, 0);
    cs_off();

    repeat (10) @(negedge clk);
    chk("wr_queue_drained", wr_exp_q.size(), 0);
    chk("byte_queue_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
